// File: rtl/bcd_pkg.sv
// Shared constants, state encoding and digit helpers for the serial packed-BCD
// adder/subtractor.
package bcd_pkg;

    localparam int         BCD_W    = 4;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Per-digit nines complement; subtraction is A + (9-B) + carry.
    function automatic logic [3:0] nines_comp(input logic [3:0] digit);
        return BCD_MAX - digit;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Combinational single-digit decimal adder: binary sum of two nibbles plus
// carry, with +6 correction whenever the binary sum leaves the 0..9 range.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci,
    output logic [3:0] s,
    output logic       co
);

    logic [4:0] sum_bin;

    // Binary sum, then decimal correction on overflow past nine.
    always_comb begin
        sum_bin = {1'b0, a} + {1'b0, b} + {4'b0000, ci};
        if (sum_bin > {1'b0, BCD_MAX}) begin
            s  = sum_bin[3:0] + BCD_CORR;
            co = 1'b1;
        end else begin
            s  = sum_bin[3:0];
            co = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Digit-serial packed-BCD adder/subtractor, one digit per clock, LSD first.
// A single bcd_digit_adder is time-multiplexed over the digits; the operand
// registers shift right so the active digit always sits in bits [3:0].
// Optional build macro BCD_DIGIT_CHECK_EN adds a sticky invalid-digit flag
// reported on err alongside out_valid; without it err is tied low.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BCD_W*DIGITS-1:0] A,
    input  logic [BCD_W*DIGITS-1:0] B,
    input  logic                    op_sub,
    input  logic                    Cin,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BCD_W*DIGITS-1:0] S,
    output logic                    Cout,
    output logic                    err
);

    localparam int                W     = BCD_W * DIGITS;
    localparam int                CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(DIGITS - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [W-1:0]     a_q,     a_d;
    logic [W-1:0]     b_q,     b_d;
    logic             sub_q,   sub_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     s_q,     s_d;
    logic             cout_q,  cout_d;

    logic [3:0]       dig_b;
    logic [3:0]       dig_s;
    logic             dig_co;

    // Subtract feeds the nines complement of the current B digit.
    always_comb begin
        dig_b = sub_q ? nines_comp(b_q[3:0]) : b_q[3:0];
    end

    bcd_digit_adder u_digit (
        .a  (a_q[3:0]),
        .b  (dig_b),
        .ci (carry_q),
        .s  (dig_s),
        .co (dig_co)
    );

    // Next-state, operand capture, digit write-back and final carry.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        s_d     = s_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    a_d     = A;
                    b_d     = B;
                    sub_d   = op_sub;
                    carry_d = op_sub ? ~Cin : Cin;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                s_d[BCD_W*int'(cnt_q) +: BCD_W] = dig_s;
                carry_d = dig_co;
                a_d     = a_q >> BCD_W;
                b_d     = b_q >> BCD_W;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    cout_d  = dig_co;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign S         = s_q;
    assign Cout      = cout_q;

`ifdef BCD_DIGIT_CHECK_EN
    logic err_q, err_d;

    // Sticky flag for any raw A or B digit above nine; cleared while idle.
    always_comb begin
        err_d = err_q;
        case (state_q)
            IDLE:    err_d = 1'b0;
            RUN:     if ((a_q[3:0] > BCD_MAX) || (b_q[3:0] > BCD_MAX)) err_d = 1'b1;
            default: err_d = err_q;
        endcase
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q & out_valid;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Self-checking bench for bcd_serial_addsub (DIGITS=4): table-driven vectors
// through a scoreboard, plus hand sequences for latency, backpressure and
// asynchronous reset abort.
module tb_bcd_serial_addsub;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;
`ifdef BCD_DIGIT_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         op_sub;
    logic         Cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] S;
    logic         Cout;
    logic         err;

    always #5 clk = ~clk;

    bcd_serial_addsub #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .op_sub    (op_sub),
        .Cin       (Cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .Cout      (Cout),
        .err       (err)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } vec_t;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         e;
    } exp_t;

    localparam int NV = 12;
    vec_t vecs [NV];
    exp_t sbq [$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard: pop and compare whenever a result is handed over.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            if (out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    fail_now("unexpected_result");
                end else begin
                    mon_e = sbq.pop_front();
                    check("S", S, mon_e.s);
                    check("Cout", W'(Cout), W'(mon_e.c));
                    check("err", W'(err), W'(mon_e.e));
                end
            end
            if (!out_valid) check("err_not_valid", W'(err), W'(1'b0));
        end
    end

    // Drive one command, wait (bounded) for acceptance, optionally score it.
    task automatic do_op(input vec_t v, input bit push);
        int waited;
        waited   = 0;
        A        = v.a;
        B        = v.b;
        op_sub   = v.sub;
        Cin      = v.cin;
        in_valid = 1'b1;
        while (!in_ready && waited < 100) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) sbq.push_back('{v.s, v.c, v.e & CHK});
        #1;
        in_valid = 1'b0;
        A        = W'($urandom);
        B        = W'($urandom);
        op_sub   = 1'($urandom);
        Cin      = 1'($urandom);
    endtask

    task automatic wait_drain();
        int waited;
        waited = 0;
        while (sbq.size() != 0 && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain", W'(sbq.size()), W'(0));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int   k;
        rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; op_sub = 1'b0; Cin = 1'b0; out_ready = 1'b1;

        //          a         b         sub   cin   s         c     e
        vecs[0]  = '{16'h1234, 16'h5678, 1'b0, 1'b0, 16'h6912, 1'b0, 1'b0};
        vecs[1]  = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[2]  = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[3]  = '{16'h5000, 16'h1234, 1'b1, 1'b0, 16'h3766, 1'b1, 1'b0};
        vecs[4]  = '{16'h1234, 16'h5000, 1'b1, 1'b0, 16'h6234, 1'b0, 1'b0};
        vecs[5]  = '{16'h9999, 16'h9999, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 16'h9999, 1'b0, 1'b0};
        vecs[7]  = '{16'h9999, 16'h9999, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[8]  = '{16'h4567, 16'h5433, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[9]  = '{16'h1000, 16'h0001, 1'b1, 1'b1, 16'h0998, 1'b1, 1'b0};
        vecs[10] = '{16'h00A0, 16'h0001, 1'b0, 1'b0, 16'h0101, 1'b0, 1'b1};
        vecs[11] = '{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", W'(in_ready), W'(1'b1));
        check("rst_out_valid", W'(out_valid), W'(1'b0));
        check("rst_S", S, W'(0));
        check("rst_Cout", W'(Cout), W'(1'b0));
        check("rst_err", W'(err), W'(1'b0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Latency: out_valid in the fifth period after the accept edge, for one period.
        A = 16'h1234; B = 16'h5678; op_sub = 1'b0; Cin = 1'b0; in_valid = 1'b1;
        check("lat_in_ready", W'(in_ready), W'(1'b1));
        @(posedge clk);
        sbq.push_back('{16'h6912, 1'b0, 1'b0});
        #1;
        in_valid = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check($sformatf("lat_out_valid_%0d", i), W'(out_valid), W'(i == 5));
            check($sformatf("lat_in_ready_%0d", i), W'(in_ready), W'(1'b0));
        end
        @(negedge clk);
        check("lat_out_valid_drop", W'(out_valid), W'(1'b0));
        check("lat_idle", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;

        // Table vectors, back to back.
        for (int i = 0; i < NV; i++) do_op(vecs[i], 1'b1);
        wait_drain();

        // Backpressure: hold out_ready low in DONE, poke in_valid meanwhile.
        out_ready = 1'b0;
        v = '{16'h8765, 16'h4321, 1'b0, 1'b0, 16'h3086, 1'b1, 1'b0};
        do_op(v, 1'b1);
        for (int i = 0; i < 3; i++) begin
            in_valid = ~in_valid;
            check("bp_run_in_ready", W'(in_ready), W'(1'b0));
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_out_valid", W'(out_valid), W'(1'b1));
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            A = 16'h1111;
            @(negedge clk);
            check("bp_hold_valid", W'(out_valid), W'(1'b1));
            check("bp_hold_S", S, 16'h3086);
            check("bp_hold_Cout", W'(Cout), W'(1'b1));
            check("bp_hold_in_ready", W'(in_ready), W'(1'b0));
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_after_valid", W'(out_valid), W'(1'b0));
        check("bp_after_in_ready", W'(in_ready), W'(1'b1));
        check("bp_queue", W'(sbq.size()), W'(0));
        @(posedge clk); #1;

        // Reset two cycles into RUN discards the operation immediately.
        v = '{16'h4321, 16'h1111, 1'b0, 1'b0, 16'h5432, 1'b0, 1'b0};
        do_op(v, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("abort_out_valid", W'(out_valid), W'(1'b0));
        check("abort_S", S, W'(0));
        check("abort_Cout", W'(Cout), W'(1'b0));
        check("abort_in_ready", W'(in_ready), W'(1'b1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        v = '{16'h0005, 16'h0005, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0};
        do_op(v, 1'b1);
        wait_drain();

        repeat (3) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
